// File: rtl/n1_pagu_pkg.sv
// Shared types for the n1 program-bus AGU and its fetch sequencer.
package n1_pagu_pkg;

  // Next-address source selected by FC
  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_REL = 2'd1,
    SRC_ABS = 2'd2,
    SRC_MEM = 2'd3
  } src_t;

  // Fetch sequencer states (RETRY only reachable with N1_PAGU_RTY_EN)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RETRY = 2'd3
  } state_t;

  // Width of the consecutive-retry counter (RTY_LIMIT is at most 15)
  localparam int RTY_CNT_W = 4;

endpackage

// File: rtl/n1_pagu_adr_calc.sv
// Combinational next-address computation for n1_pagu_fetch.
// All sums are modulo 2^ADR_WIDTH; relative offsets are sign-extended,
// absolute and memory fields are zero-extended before their offset is added.
module n1_pagu_adr_calc
  import n1_pagu_pkg::*;
#(
  parameter int                    ADR_WIDTH        = 16,
  parameter int                    AADR_WIDTH       = 14,
  parameter int                    RADR_WIDTH       = 13,
  parameter int                    MADR_WIDTH       = 8,
  parameter logic [ADR_WIDTH-1:0]  PBUS_AADR_OFFSET = '0,
  parameter logic [ADR_WIDTH-1:0]  PBUS_MADR_OFFSET = '0
)(
  input  logic [ADR_WIDTH-1:0]  areg,
  input  src_t                  src,
  input  logic                  aadr_sel,
  input  logic                  madr_sel,
  input  logic [AADR_WIDTH-1:0] aadr,
  input  logic [RADR_WIDTH-1:0] radr,
  input  logic [MADR_WIDTH-1:0] madr,
  input  logic [ADR_WIDTH-1:0]  ps0,
  output logic [ADR_WIDTH-1:0]  next_adr
);

  logic signed [RADR_WIDTH-1:0] radr_s;
  logic        [ADR_WIDTH-1:0]  radr_ext;
  logic        [ADR_WIDTH-1:0]  aadr_ext;
  logic        [ADR_WIDTH-1:0]  madr_ext;

  assign radr_s   = radr;
  assign radr_ext = ADR_WIDTH'(radr_s);
  assign aadr_ext = ADR_WIDTH'(aadr);
  assign madr_ext = ADR_WIDTH'(madr);

  // Source mux; carries out of the top bit are dropped so addresses wrap
  always_comb begin
    next_adr = areg + ADR_WIDTH'(1);
    unique case (src)
      SRC_SEQ: next_adr = areg + ADR_WIDTH'(1);
      SRC_REL: next_adr = areg + radr_ext;
      SRC_ABS: next_adr = aadr_sel ? ps0 : (PBUS_AADR_OFFSET + aadr_ext);
      SRC_MEM: next_adr = madr_sel ? ps0 : (PBUS_MADR_OFFSET + madr_ext);
      default: next_adr = areg + ADR_WIDTH'(1);
    endcase
  end

endmodule

// File: rtl/n1_pagu_fetch.sv
// n1 program-bus AGU with pipelined Wishbone fetch sequencer.
// Computes the next fetch address, runs one CYC/STB/ADR transaction per FC
// request and commits the address into AREG when the slave acknowledges.
// Optional feature macro: N1_PAGU_RTY_EN adds the pbus_rty_i port, a RETRY
// state and a consecutive-retry counter bounded by RTY_LIMIT.
module n1_pagu_fetch
  import n1_pagu_pkg::*;
#(
  parameter int                    ADR_WIDTH        = 16,
  parameter int                    AADR_WIDTH       = 14,
  parameter int                    RADR_WIDTH       = 13,
  parameter int                    MADR_WIDTH       = 8,
  parameter logic [ADR_WIDTH-1:0]  PBUS_AADR_OFFSET = '0,
  parameter logic [ADR_WIDTH-1:0]  PBUS_MADR_OFFSET = '0,
  parameter int                    RTY_LIMIT        = 4
)(
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  output logic                  pbus_cyc_o,
  output logic                  pbus_stb_o,
  output logic [ADR_WIDTH-1:0]  pbus_adr_o,
  input  logic                  pbus_stall_i,
  input  logic                  pbus_ack_i,
  input  logic                  pbus_err_i,
`ifdef N1_PAGU_RTY_EN
  input  logic                  pbus_rty_i,
`endif
  input  logic                  fc2pagu_req_i,
  input  logic [1:0]            fc2pagu_src_i,
  input  logic                  ir2pagu_aadr_sel_i,
  input  logic                  ir2pagu_madr_sel_i,
  input  logic [AADR_WIDTH-1:0] ir2pagu_aadr_i,
  input  logic [RADR_WIDTH-1:0] ir2pagu_radr_i,
  input  logic [MADR_WIDTH-1:0] ir2pagu_madr_i,
  input  logic [ADR_WIDTH-1:0]  prs2pagu_ps0_i,
  output logic                  pagu2fc_busy_o,
  output logic                  pagu2fc_done_o,
  output logic                  pagu2fc_err_o,
  output logic [ADR_WIDTH-1:0]  pagu2prs_areg_o,
  output logic [1:0]            prb_pagu_state_o
);

  state_t                 state;
  logic                   cyc;
  logic                   stb;
  logic                   done;
  logic                   err;
  logic [ADR_WIDTH-1:0]   adr;
  logic [ADR_WIDTH-1:0]   areg;
  logic [ADR_WIDTH-1:0]   next_adr;
  logic                   resp_phase;
`ifdef N1_PAGU_RTY_EN
  logic [RTY_CNT_W-1:0]   rty_cnt;
`endif

  n1_pagu_adr_calc #(
    .ADR_WIDTH        (ADR_WIDTH),
    .AADR_WIDTH       (AADR_WIDTH),
    .RADR_WIDTH       (RADR_WIDTH),
    .MADR_WIDTH       (MADR_WIDTH),
    .PBUS_AADR_OFFSET (PBUS_AADR_OFFSET),
    .PBUS_MADR_OFFSET (PBUS_MADR_OFFSET)
  ) u_adr_calc (
    .areg     (areg),
    .src      (src_t'(fc2pagu_src_i)),
    .aadr_sel (ir2pagu_aadr_sel_i),
    .madr_sel (ir2pagu_madr_sel_i),
    .aadr     (ir2pagu_aadr_i),
    .radr     (ir2pagu_radr_i),
    .madr     (ir2pagu_madr_i),
    .ps0      (prs2pagu_ps0_i),
    .next_adr (next_adr)
  );

  // The slave may answer in WAIT, or in ADDR on the cycle the strobe is accepted
  assign resp_phase = (state == ST_WAIT) || ((state == ST_ADDR) && !pbus_stall_i);

  // Fetch sequencer: all bus and FC handshake outputs are registered here
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      state <= ST_IDLE;
      cyc   <= 1'b0;
      stb   <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      adr   <= '0;
      areg  <= '0;
`ifdef N1_PAGU_RTY_EN
      rty_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fc2pagu_req_i) begin
            adr   <= next_adr;
            cyc   <= 1'b1;
            stb   <= 1'b1;
            state <= ST_ADDR;
`ifdef N1_PAGU_RTY_EN
            rty_cnt <= '0;
`endif
          end
        end
        ST_ADDR, ST_WAIT: begin
          if (resp_phase) begin
            stb <= 1'b0;
            if (pbus_err_i) begin
              err   <= 1'b1;
              cyc   <= 1'b0;
              state <= ST_IDLE;
`ifdef N1_PAGU_RTY_EN
            end else if (pbus_rty_i) begin
              if (rty_cnt == RTY_CNT_W'(RTY_LIMIT)) begin
                err     <= 1'b1;
                cyc     <= 1'b0;
                rty_cnt <= '0;
                state   <= ST_IDLE;
              end else begin
                rty_cnt <= rty_cnt + RTY_CNT_W'(1);
                state   <= ST_RETRY;
              end
`endif
            end else if (pbus_ack_i) begin
              areg  <= adr;
              done  <= 1'b1;
              cyc   <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
`ifdef N1_PAGU_RTY_EN
        ST_RETRY: begin
          // One idle beat with the cycle held, then reissue the same address
          stb   <= 1'b1;
          state <= ST_ADDR;
        end
`endif
        default: begin
          cyc   <= 1'b0;
          stb   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pbus_cyc_o       = cyc;
  assign pbus_stb_o       = stb;
  assign pbus_adr_o       = adr;
  assign pagu2fc_busy_o   = (state != ST_IDLE);
  assign pagu2fc_done_o   = done;
  assign pagu2fc_err_o    = err;
  assign pagu2prs_areg_o  = areg;
  assign prb_pagu_state_o = state;

endmodule
